instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set instruction-memory address width; capacity = 2^ADDR_W words.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 clear  in  1  synchronous clear of write pointer, full flag and err_code.
REQ-005 in_valid  in  1  encode request present.
REQ-006 in_ready  out  1  encoder can accept a request.
REQ-007 op_class  in  2  00 data-processing, 01 LDR/STR, 10 branch, 11 illegal.
REQ-008 cond  in  4  condition field; 1111 illegal.
REQ-009 opcode  in  4  DP opcode.
REQ-010 imm_flag  in  1  DP: operand 2 is imm12; LS: offset is imm12.
REQ-011 s_bit  in  1  DP: S bit; LS: L bit (1=LDR); branch: link.
REQ-012 up  in  1  LS U bit (1=add offset).
REQ-013 shift_reg  in  1  shift amount taken from rs.
REQ-014 sh_type  in  2  shift type.
REQ-015 rn, rd, rm, rs  in  4 each  register fields.
REQ-016 imm12  in  12  immediate field.
REQ-017 br_off  in  32  signed branch byte offset.
REQ-018 mem_we  out  1  instruction-memory write strobe.
REQ-019 mem_addr  out  ADDR_W  write address (= write pointer).
REQ-020 mem_wdata  out  32  encoded instruction word.
REQ-021 full  out  1  all 2^ADDR_W words written since last clear/reset.
REQ-022 err  out  1  one-cycle pulse: request rejected.
REQ-023 err_code  out  2  cause of last rejection; held until next error/clear.

Function
REQ-024 FSM states IDLE, ENC, WR; in_ready SHALL be 1 only in IDLE with full=0.
REQ-025 Handshake: in_valid&in_ready at edge t0 SHALL register all fields and go IDLE->ENC; in_valid ignored otherwise.
REQ-026 ENC SHALL register the word and validity; valid -> WR at t1; invalid -> IDLE at t1 with err=1 during t1..t2, no write.
REQ-027 WR SHALL hold mem_we=1 for exactly one cycle (t1..t2), then IDLE at t2 with pointer incremented; throughput one word per 3 cycles.
REQ-028 Error priority: op_class=11 -> err_code 11; else cond=1111 -> 10; else branch with br_off[1:0]!=0 or br_off[31:24]!={8{br_off[23]}} -> 01.
REQ-029 All words: [31:28]=cond; [27:26]=op_class.
REQ-030 DP: [25]=imm_flag, [24:21]=opcode, [20]=S, [19:16]=rn, [15:12]=rd; opcodes 1000/1001/1010 SHALL force S=1 and rd=0000.
REQ-031 LS: [25]=~imm_flag, [24]=1, [23]=up, [22:21]=00, [20]=L, [19:16]=rn, [15:12]=rd.
REQ-032 DP/LS operand [11:0]: imm12 when DP imm_flag=1 or LS imm_flag=1; else [11:8]=rs if shift_reg else 0000, [7]=0, [6:5]=sh_type, [4]=shift_reg, [3:0]=rm.
REQ-033 Branch: [25]=1, [24]=link, [23:22]={2{br_off[23]}}, [21:0]=br_off[23:2].
REQ-034 Pointer SHALL wrap from 2^ADDR_W-1 to 0 on the final write, setting full=1; full blocks further requests.
REQ-035 clear SHALL take priority in any state: pointer=0, full=0, err_code=00, FSM->IDLE, in-flight request dropped, no mem_we.
REQ-036 mem_wdata/mem_addr SHALL be stable while mem_we=1.

Reset
REQ-037 reset low SHALL immediately force IDLE, pointer=0, mem_we=0, mem_wdata=0, full=0, err=0, err_code=00, in_ready=1 after release.

Verification
REQ-038 DP cond=1110 opcode=0100 imm_flag=1 s_bit=0 rn=1 rd=2 imm12=0x005 -> one mem_we, mem_addr=0, mem_wdata=0xE2812005.
REQ-039 DP CMP opcode=1010 s_bit=0 imm_flag=0 rn=3 rd=7 rm=4 shift_reg=0 sh_type=00 -> mem_wdata=0xE1530004.
REQ-040 Branch cond=0000 s_bit=1 br_off=0xFFFFFFF8 -> mem_wdata=0x0BFFFFFE.
REQ-041 Branch br_off=0x00000006 -> err pulse, err_code=01, no mem_we, mem_addr unchanged; then op_class=11 -> err_code=11.
REQ-042 2^ADDR_W back-to-back valid requests -> full=1, in_ready=0, mem_addr=0; clear -> full=0, in_ready=1.
REQ-043 reset asserted during WR -> mem_we=0 without clock edge; pointer=0 after release.

Source files
------------

// File: rtl/instr_encoder.sv
// Encodes one ARM-style instruction per request and writes it into the next
// instruction-memory word. The FSM walks IDLE -> ENC -> WR, so one word is written every three cycles.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op_class,
    input  logic [3:0]        cond,
    input  logic [3:0]        opcode,
    input  logic              imm_flag,
    input  logic              s_bit,
    input  logic              up,
    input  logic              shift_reg,
    input  logic [1:0]        sh_type,
    input  logic [3:0]        rn,
    input  logic [3:0]        rd,
    input  logic [3:0]        rm,
    input  logic [3:0]        rs,
    input  logic [11:0]       imm12,
    input  logic [31:0]       br_off,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t state, next_state;

    // Handshake: a request is taken on a rising edge where in_valid and
    // in_ready are both 1 and clear is 0; in_valid is ignored at any other time.
    logic accept;

    logic [1:0]        r_op_class;
    logic [3:0]        r_cond, r_opcode, r_rn, r_rd, r_rm, r_rs;
    logic              r_imm_flag, r_s_bit, r_up, r_shift_reg;
    logic [1:0]        r_sh_type;
    logic [11:0]       r_imm12;
    logic [31:0]       r_br_off;
    logic [ADDR_W-1:0] ptr;

    logic [31:0] enc_word;
    logic [11:0] operand;
    logic [1:0]  enc_code;
    logic        enc_ok;
    logic        br_bad;
    logic        dp_test;

    assign in_ready  = (state == IDLE) && !full;
    assign accept    = in_valid && in_ready && !clear;
    assign mem_we    = (state == WR) && !clear;
    assign mem_addr  = ptr;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op_class  <= 2'b00;
            r_cond      <= 4'h0;
            r_opcode    <= 4'h0;
            r_imm_flag  <= 1'b0;
            r_s_bit     <= 1'b0;
            r_up        <= 1'b0;
            r_shift_reg <= 1'b0;
            r_sh_type   <= 2'b00;
            r_rn        <= 4'h0;
            r_rd        <= 4'h0;
            r_rm        <= 4'h0;
            r_rs        <= 4'h0;
            r_imm12     <= 12'h000;
            r_br_off    <= 32'h0;
        end else if (accept) begin
            r_op_class  <= op_class;
            r_cond      <= cond;
            r_opcode    <= opcode;
            r_imm_flag  <= imm_flag;
            r_s_bit     <= s_bit;
            r_up        <= up;
            r_shift_reg <= shift_reg;
            r_sh_type   <= sh_type;
            r_rn        <= rn;
            r_rd        <= rd;
            r_rm        <= rm;
            r_rs        <= rs;
            r_imm12     <= imm12;
            r_br_off    <= br_off;
        end
    end

    // Branch offsets must be word aligned and fit the signed 24-bit field.
    always_comb begin
        enc_word = 32'h0;
        enc_code = 2'b00;
        enc_ok   = 1'b1;
        br_bad   = (r_br_off[1:0] != 2'b00) || (r_br_off[31:24] != {8{r_br_off[23]}});
        dp_test  = (r_opcode[3:2] == 2'b10) && (r_opcode[1:0] != 2'b11);
        operand  = r_imm_flag ? r_imm12
                              : {(r_shift_reg ? r_rs : 4'h0), 1'b0, r_sh_type, r_shift_reg, r_rm};

        if (r_op_class == 2'b11) begin
            enc_ok   = 1'b0;
            enc_code = 2'b11;
        end else if (r_cond == 4'hF) begin
            enc_ok   = 1'b0;
            enc_code = 2'b10;
        end else if ((r_op_class == 2'b10) && br_bad) begin
            enc_ok   = 1'b0;
            enc_code = 2'b01;
        end

        case (r_op_class)
            2'b00: enc_word = {r_cond, 2'b00, r_imm_flag, r_opcode, (r_s_bit | dp_test),
                               r_rn, (dp_test ? 4'h0 : r_rd), operand};
            2'b01: enc_word = {r_cond, 2'b01, ~r_imm_flag, 1'b1, r_up, 2'b00, r_s_bit,
                               r_rn, r_rd, operand};
            2'b10: enc_word = {r_cond, 2'b10, 1'b1, r_s_bit, {2{r_br_off[23]}}, r_br_off[23:2]};
            default: enc_word = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ENC;
            ENC:     next_state = enc_ok ? WR : IDLE;
            WR:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (clear) next_state = IDLE;
    end

    // mem_wdata only loads on a valid encode, so it holds steady through WR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
            mem_wdata <= 32'h0;
        end else if (clear) begin
            ptr      <= '0;
            full     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            err <= 1'b0;
            if (state == ENC) begin
                if (enc_ok) begin
                    mem_wdata <= enc_word;
                end else begin
                    err      <= 1'b1;
                    err_code <= enc_code;
                end
            end
            if (state == WR) begin
                ptr <= ptr + 1'b1;
                if (ptr == {ADDR_W{1'b1}}) full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed words, error codes,
// wrap/full, clear and asynchronous reset behaviour.
module tb_instr_encoder;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    op_class = '0;
    logic [3:0]    cond = '0, opcode = '0, rn = '0, rd = '0, rm = '0, rs = '0;
    logic          imm_flag = 1'b0, s_bit = 1'b0, up = 1'b0, shift_reg = 1'b0;
    logic [1:0]    sh_type = '0;
    logic [11:0]   imm12 = '0;
    logic [31:0]   br_off = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          full, err;
    logic [1:0]    err_code, state_dbg;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .op_class(op_class), .cond(cond), .opcode(opcode), .imm_flag(imm_flag),
        .s_bit(s_bit), .up(up), .shift_reg(shift_reg), .sh_type(sh_type),
        .rn(rn), .rd(rd), .rm(rm), .rs(rs), .imm12(imm12), .br_off(br_off),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .full(full),
        .err(err), .err_code(err_code), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // scoreboard: {addr, word} for every write the bench expects
    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] exp_e;

    always @(negedge clk) begin
        if (reset && mem_we) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", 32'd1, 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("sb_addr", 32'(mem_addr), 32'(exp_e[AW+31:32]));
                check("sb_data", mem_wdata, exp_e[31:0]);
            end
        end
    end

    logic          obs_we, obs_err;
    logic [AW-1:0] obs_addr;
    logic [31:0]   obs_wdata;
    logic [1:0]    obs_code;
    logic [AW-1:0] ptr = '0;

    // driver tasks
    task automatic set_fields(input logic [1:0] c_cls, input logic [3:0] c_cond,
                              input logic [3:0] c_op, input logic c_imm, input logic c_s,
                              input logic c_up, input logic c_shr, input logic [1:0] c_sht,
                              input logic [3:0] c_rn, input logic [3:0] c_rd,
                              input logic [3:0] c_rm, input logic [3:0] c_rs,
                              input logic [11:0] c_imm12, input logic [31:0] c_br);
        op_class = c_cls; cond = c_cond; opcode = c_op; imm_flag = c_imm; s_bit = c_s;
        up = c_up; shift_reg = c_shr; sh_type = c_sht; rn = c_rn; rd = c_rd;
        rm = c_rm; rs = c_rs; imm12 = c_imm12; br_off = c_br;
    endtask

    // Called at a falling edge; returns three cycles later at a falling edge.
    task automatic handshake(input string tag);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_enc_we"}, 32'(mem_we), 32'd0);
        @(negedge clk);
        obs_we = mem_we; obs_err = err; obs_addr = mem_addr;
        obs_wdata = mem_wdata; obs_code = err_code;
        @(negedge clk);
        check({tag, "_we_off"}, 32'(mem_we), 32'd0);
        check({tag, "_err_off"}, 32'(err), 32'd0);
    endtask

    task automatic expect_write(input string tag, input logic [31:0] word);
        exp_q.push_back({ptr, word});
        handshake(tag);
        check({tag, "_we"}, 32'(obs_we), 32'd1);
        check({tag, "_addr"}, 32'(obs_addr), 32'(ptr));
        check({tag, "_word"}, obs_wdata, word);
        ptr = ptr + 1'b1;
    endtask

    task automatic expect_error(input string tag, input logic [1:0] code);
        handshake(tag);
        check({tag, "_we"}, 32'(obs_we), 32'd0);
        check({tag, "_err"}, 32'(obs_err), 32'd1);
        check({tag, "_code"}, 32'(obs_code), 32'(code));
        check({tag, "_addr"}, 32'(mem_addr), 32'(ptr));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);

        // cls cond op imm s up shr sht rn rd rm rs imm12 br_off
        set_fields(2'b00, 4'hE, 4'b0100, 1, 0, 0, 0, 2'b00, 4'd1, 4'd2, 4'd0, 4'd0, 12'h005, 32'h0);
        expect_write("add_imm", 32'hE2812005);
        set_fields(2'b00, 4'hE, 4'b1010, 0, 0, 0, 0, 2'b00, 4'd3, 4'd7, 4'd4, 4'd0, 12'h000, 32'h0);
        expect_write("cmp_reg", 32'hE1530004);
        set_fields(2'b10, 4'h0, 4'h0, 0, 1, 0, 0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 12'h000, 32'hFFFFFFF8);
        expect_write("bl_back", 32'h0BFFFFFE);
        set_fields(2'b01, 4'hE, 4'h0, 1, 1, 1, 0, 2'b00, 4'd1, 4'd0, 4'd0, 4'd0, 12'h010, 32'h0);
        expect_write("ldr_imm", 32'hE5910010);
        set_fields(2'b01, 4'hE, 4'h0, 0, 0, 0, 1, 2'b10, 4'd2, 4'd3, 4'd5, 4'd6, 12'h000, 32'h0);
        expect_write("str_regsh", 32'hE7023655);
        set_fields(2'b00, 4'h0, 4'b1101, 0, 1, 0, 0, 2'b01, 4'd0, 4'd1, 4'd2, 4'd9, 12'h000, 32'h0);
        expect_write("mov_rs_ign", 32'h01B01022);
        set_fields(2'b00, 4'hE, 4'b1000, 1, 0, 0, 0, 2'b00, 4'd4, 4'd5, 4'd0, 4'd0, 12'hFFF, 32'h0);
        expect_write("tst_imm", 32'hE3140FFF);

        set_fields(2'b10, 4'hE, 4'h0, 0, 0, 0, 0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 12'h000, 32'h00000006);
        expect_error("br_misalign", 2'b01);
        set_fields(2'b11, 4'hE, 4'h0, 0, 0, 0, 0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 12'h000, 32'h00000006);
        expect_error("illegal_cls", 2'b11);
        set_fields(2'b00, 4'hF, 4'h0, 0, 0, 0, 0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 12'h000, 32'h0);
        expect_error("cond_nv", 2'b10);
        set_fields(2'b10, 4'hE, 4'h0, 0, 0, 0, 0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 12'h000, 32'h01000000);
        expect_error("br_range", 2'b01);

        set_fields(2'b10, 4'hE, 4'h0, 0, 0, 0, 0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 12'h000, 32'h00000100);
        expect_write("b_fwd", 32'hEA000040);
        check("code_held", 32'(err_code), 32'd1);

        // clear while the request sits in ENC drops it
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_we", 32'(mem_we), 32'd0);
        check("clr_code", 32'(err_code), 32'd0);
        check("clr_addr", 32'(mem_addr), 32'd0);
        check("clr_ready", 32'(in_ready), 32'd1);
        ptr = '0;
        @(negedge clk);
        check("clr_we2", 32'(mem_we), 32'd0);

        for (int i = 0; i < (1 << AW); i++) begin
            set_fields(2'b00, 4'hE, 4'b0100, 1, 0, 0, 0, 2'b00, 4'd1, 4'd2, 4'd0, 4'd0, 12'(i), 32'h0);
            expect_write("fill", 32'hE2812000 | 32'(i));
            check("fill_full", 32'(full), 32'(i == (1 << AW) - 1));
        end
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_addr", 32'(mem_addr), 32'd0);
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check("full_blocked", 32'(state_dbg), 32'd0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("unfull", 32'(full), 32'd0);
        check("unfull_ready", 32'(in_ready), 32'd1);

        set_fields(2'b00, 4'hE, 4'b0100, 1, 0, 0, 0, 2'b00, 4'd1, 4'd2, 4'd0, 4'd0, 12'h005, 32'h0);
        expect_write("pre_rst", 32'hE2812005);
        // asynchronous reset in the middle of WR
        exp_q.push_back({ptr, 32'hE2812005});
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("wr_we", 32'(mem_we), 32'd1);
        check("wr_addr", 32'(mem_addr), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("async_we", 32'(mem_we), 32'd0);
        check("async_wdata", mem_wdata, 32'h0);
        check("async_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_addr", 32'(mem_addr), 32'd0);
        check("post_rst_ready", 32'(in_ready), 32'd1);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
